sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, SRAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, SRAM data width.
REQ-003 SHALL have ports: clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have ports: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: a_req, b_req  input  1 each  client access request, level, held until ack.
REQ-006 SHALL have ports: a_we, b_we  input  1 each  1 = write, 0 = read; valid while req high.
REQ-007 SHALL have ports: a_addr, b_addr  input  ADDR_W each  client address.
REQ-008 SHALL have ports: a_wdata, b_wdata  input  DATA_W each  client write data.
REQ-009 SHALL have ports: a_ack, b_ack  output  1 each  one-cycle completion pulse.
REQ-010 SHALL have ports: rdata  output  DATA_W  last read data, shared by both clients, valid from ack cycle onward.
REQ-011 SHALL have ports: a_gnt, b_gnt  output  1 each  client owns SRAM (SETUP through HOLD).
REQ-012 SHALL have ports: busy  output  1  state != IDLE.
REQ-013 SHALL have ports: sram_addr  output  ADDR_W  SRAM address.
REQ-014 SHALL have ports: sram_data  inout  DATA_W  SRAM bidirectional data bus.
REQ-015 SHALL have ports: sram_rd_n, sram_wr_n  output  1 each  SRAM read/write enables, active low.

Function
REQ-016 SHALL use FSM states IDLE, SETUP, ACCESS, HOLD; every transaction visits SETUP->ACCESS->HOLD->IDLE, one state per cycle, no waits.
REQ-017 IDLE: with any req high, SHALL pick a winner per REQ-018, latch its we/addr/wdata into internal registers, go to SETUP; else stay in IDLE.
REQ-018 Round-robin: both requests high -> grant the client not granted last; after reset, A has priority; a single request is always granted.
REQ-019 SETUP: sram_addr = latched address; read: sram_rd_n = 0; write: sram_data driven with latched wdata, strobes high.
REQ-020 ACCESS: read: sram_rd_n = 0, rdata captured from sram_data at the end of ACCESS; write: sram_wr_n = 0, data still driven.
REQ-021 HOLD: both strobes high; address and (for write) sram_data held; winning client's ack = 1 for exactly this cycle; last-grant pointer updated.
REQ-022 Latency SHALL be: ack high 3 cycles after the rising edge at which IDLE accepted the request; throughput 1 access per 4 cycles.
REQ-023 sram_data SHALL be high-impedance except in SETUP/ACCESS/HOLD of a write; sram_rd_n and sram_wr_n SHALL never both be 0.
REQ-024 Client inputs SHALL be ignored outside IDLE; changes to addr/we/wdata mid-transaction have no effect.
REQ-025 A client keeping req high after its ack SHALL be re-arbitrated in the next IDLE, with the other client winning if it is also requesting.
REQ-026 sram_addr SHALL keep its last value in IDLE and never float.
REQ-027 rdata SHALL be unchanged by write transactions.

Reset
REQ-028 On rst = 1, immediately and independent of clk: state = IDLE; sram_rd_n = sram_wr_n = 1; sram_data = Z; sram_addr = 0; rdata = 0; acks, grants, busy = 0; priority = A.
REQ-029 Reset mid-transaction SHALL abort it without ack; the client re-requests after reset is released.
REQ-030 First arbitration SHALL occur at the first rising edge after rst falls.

Structure
REQ-031 Package sram_pkg SHALL hold state encodings and ADDR_W/DATA_W defaults; later SRAM-side blocks (FIFO interface) share it.
REQ-032 Two-way round-robin picker SHALL be a sub-module rr_arb2 (inputs req[1:0], last; outputs grant[1:0]); the rest stays flat.

Verification
REQ-033 Single write: A writes 8'h5A to 11'h003 -> sram_wr_n low exactly 1 cycle (ACCESS), sram_addr = 11'h003 for SETUP..HOLD, a_ack 3 cycles after acceptance.
REQ-034 Read back: B reads 11'h003 with SRAM model returning 8'h5A -> rdata = 8'h5A in b_ack cycle, sram_rd_n low SETUP+ACCESS only.
REQ-035 Contention: a_req and b_req held high for 4 transactions after reset -> grant order A,B,A,B, one ack per 4 cycles.
REQ-036 Mid-transaction input change: A write to 11'h010 accepted, a_addr switched to 11'h7FF in SETUP -> SRAM write still at 11'h010.
REQ-037 Reset in ACCESS of a write -> sram_wr_n = 1, sram_data = Z the same cycle, no ack, state IDLE, next request completes normally.
REQ-038 Assertion on all runs: never (sram_rd_n == 0 and sram_wr_n == 0); sram_data driven by DUT only during write states.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM-side blocks: default bus widths, arbiter
// state encodings and client identifiers.
package sram_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    typedef enum logic {
        CLIENT_A = 1'b0,
        CLIENT_B = 1'b1
    } client_e;

endpackage

// File: rtl/sram_arbiter_if.sv
// Client-side bundle of the SRAM arbiter: two request/ack clients plus the
// shared read data and ownership status.
interface sram_arbiter_if
    import sram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              a_req;
    logic              b_req;
    logic              a_we;
    logic              b_we;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] b_wdata;
    logic              a_ack;
    logic              b_ack;
    logic              a_gnt;
    logic              b_gnt;
    logic              busy;
    logic [DATA_W-1:0] rdata;

    modport master (
        output a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata,
        input  a_ack, b_ack, a_gnt, b_gnt, busy, rdata
    );

    modport slave (
        input  a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata,
        output a_ack, b_ack, a_gnt, b_gnt, busy, rdata
    );

endinterface

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone request always wins; on contention the
// client that was not served last wins.
module rr_arb2
    import sram_pkg::*;
(
    input  logic [1:0] req,
    input  client_e    last,
    output logic [1:0] grant
);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last == CLIENT_A) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-client arbiter for an asynchronous SRAM: each access runs
// IDLE -> SETUP -> ACCESS -> HOLD with the winner's request latched at accept.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    sram_arbiter_if.slave     bus,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data,
    output logic              sram_rd_n,
    output logic              sram_wr_n
);

    logic [1:0]        state_q, state_d;
    client_e           owner_q, owner_d;
    client_e           last_q,  last_d;
    logic              we_q,    we_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        grant;

    rr_arb2 u_rr_arb2 (
        .req   ({bus.b_req, bus.a_req}),
        .last  (last_q),
        .grant (grant)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                // Client inputs are sampled only here; later changes are ignored.
                if (|grant) begin
                    owner_d = grant[1] ? CLIENT_B : CLIENT_A;
                    we_d    = grant[1] ? bus.b_we    : bus.a_we;
                    addr_d  = grant[1] ? bus.b_addr  : bus.a_addr;
                    wdata_d = grant[1] ? bus.b_wdata : bus.a_wdata;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (!we_q) rdata_d = sram_data;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                last_d  = owner_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= CLIENT_A;
            last_q  <= CLIENT_B;   // "B served last" gives A first pick after reset
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobes decode straight from registered state, so reset releases them at once.
    assign sram_addr = addr_q;
    assign sram_rd_n = !(!we_q && (state_q == ST_SETUP || state_q == ST_ACCESS));
    assign sram_wr_n = !(we_q && state_q == ST_ACCESS);
    assign sram_data = (we_q && state_q != ST_IDLE) ? wdata_q : {DATA_W{1'bz}};

    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.a_gnt = bus.busy && (owner_q == CLIENT_A);
    assign bus.b_gnt = bus.busy && (owner_q == CLIENT_B);
    assign bus.a_ack = (state_q == ST_HOLD) && (owner_q == CLIENT_A);
    assign bus.b_ack = (state_q == ST_HOLD) && (owner_q == CLIENT_B);
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: SRAM device model on the pins plus a
// transaction-level model (round-robin winner, shadow memory, last read data).
`timescale 1ns/1ps
module tb_sram_arbiter;
    import sram_pkg::*;

    localparam int AW = 11;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] sram_addr;
    wire  [DW-1:0] sram_data;
    logic          sram_rd_n;
    logic          sram_wr_n;

    int errors = 0;
    int checks = 0;

    sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .sram_addr (sram_addr),
        .sram_data (sram_data),
        .sram_rd_n (sram_rd_n),
        .sram_wr_n (sram_wr_n)
    );

    always #5 clk = ~clk;

    // SRAM device: writes on the clock while wr_n is low, drives data while rd_n is low.
    // An undriven bus floats high, so "released" reads back as all ones.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) if (!sram_wr_n) mem[sram_addr] <= sram_data;
    assign sram_data = !sram_rd_n ? mem[sram_addr] : {DW{1'bz}};
    pullup (sram_data);

    // Transaction-level reference model.
    client_e       mdl_last;
    logic [DW-1:0] mdl_rdata;
    logic [DW-1:0] shadow [0:(1<<AW)-1];

    task automatic mdl_reset();
        mdl_last  = CLIENT_B;
        mdl_rdata = '0;
    endtask

    function automatic client_e mdl_winner(input logic ra, input logic rb);
        if (ra && rb) return (mdl_last == CLIENT_B) ? CLIENT_A : CLIENT_B;
        return ra ? CLIENT_A : CLIENT_B;
    endfunction

    // One clock; leaves the bench at the falling edge and checks bus protocol there.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (!rst) begin
            checks++;
            if (!sram_rd_n && !sram_wr_n) begin
                errors++;
                $display("FAIL strobe_overlap: rd_n=%b wr_n=%b required not both 0", sram_rd_n, sram_wr_n);
            end
            if (!bus.busy) begin
                checks++;
                if (sram_data !== {DW{1'b1}}) begin
                    errors++;
                    $display("FAIL idle_bus_released: sram_data=%h required %h (undriven)", sram_data, {DW{1'b1}});
                end
            end
        end
    endtask

    task automatic set_client(input client_e who, input logic req, input logic we,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (who == CLIENT_A) begin
            bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
        end else begin
            bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
        end
    endtask

    // Runs one uncontended transaction from IDLE and reports what the pins did.
    task automatic drive_single(input client_e who, input logic we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input bit scramble,
                                output int ack_step, output int wr_cnt, output int wr_step,
                                output int rd_mask, output bit addr_ok,
                                output logic [DW-1:0] rdata_ack, output bit other_ack);
        logic own, oth;
        ack_step = 0; wr_cnt = 0; wr_step = 0; rd_mask = 0;
        addr_ok = 1'b1; rdata_ack = '0; other_ack = 1'b0;
        set_client(who, 1'b1, we, addr, wdata);
        for (int k = 1; k <= 8 && ack_step == 0; k++) begin
            step();
            if (!sram_wr_n) begin wr_cnt++; wr_step = k; end
            if (!sram_rd_n) rd_mask |= (1 << (k - 1));
            if (bus.busy && sram_addr !== addr) addr_ok = 1'b0;
            if (k == 1 && scramble) set_client(who, 1'b1, we, {AW{1'b1}}, ~wdata);
            own = (who == CLIENT_A) ? bus.a_ack : bus.b_ack;
            oth = (who == CLIENT_A) ? bus.b_ack : bus.a_ack;
            if (oth) other_ack = 1'b1;
            if (own) begin
                ack_step  = k;
                rdata_ack = bus.rdata;
                set_client(who, 1'b0, we, addr, wdata);
            end
        end
        set_client(who, 1'b0, we, addr, wdata);
        step();
        if (ack_step != 0) begin
            mdl_last = who;
            if (we) shadow[addr] = wdata;
            else    mdl_rdata = shadow[addr];
        end
    endtask

    task automatic apply_reset();
        set_client(CLIENT_A, 1'b0, 1'b0, '0, '0);
        set_client(CLIENT_B, 1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        mdl_reset();
    endtask

    task automatic test_reset();
        set_client(CLIENT_A, 1'b0, 1'b0, '0, '0);
        set_client(CLIENT_B, 1'b0, 1'b0, '0, '0);
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;  // still before the first clock edge
        checks++;
        if ({bus.busy, bus.a_gnt, bus.b_gnt, bus.a_ack, bus.b_ack} !== 5'b0) begin
            errors++;
            $display("FAIL reset_status: busy/gnt/ack=%b required 00000",
                     {bus.busy, bus.a_gnt, bus.b_gnt, bus.a_ack, bus.b_ack});
        end
        checks++;
        if ({sram_rd_n, sram_wr_n} !== 2'b11) begin
            errors++;
            $display("FAIL reset_strobes: rd_n,wr_n=%b required 11", {sram_rd_n, sram_wr_n});
        end
        checks++;
        if (sram_addr !== '0) begin
            errors++;
            $display("FAIL reset_addr: sram_addr=%h required 000", sram_addr);
        end
        checks++;
        if (bus.rdata !== '0) begin
            errors++;
            $display("FAIL reset_rdata: rdata=%h required 00", bus.rdata);
        end
        checks++;
        if (sram_data !== {DW{1'b1}}) begin
            errors++;
            $display("FAIL reset_bus: sram_data=%h required released", sram_data);
        end
        @(negedge clk);
        step();
        rst = 1'b0;
        mdl_reset();
    endtask

    task automatic test_single_write();
        int ack_step, wr_cnt, wr_step, rd_mask; bit addr_ok, other; logic [DW-1:0] rd;
        drive_single(CLIENT_A, 1'b1, 11'h003, 8'h5A, 1'b0, ack_step, wr_cnt, wr_step, rd_mask, addr_ok, rd, other);
        checks++;
        if (ack_step !== 3) begin errors++; $display("FAIL wr_ack_latency: ack at cycle %0d required 3", ack_step); end
        checks++;
        if (wr_cnt !== 1 || wr_step !== 2) begin
            errors++; $display("FAIL wr_strobe: low %0d cycles at cycle %0d required 1 at 2", wr_cnt, wr_step);
        end
        checks++;
        if (rd_mask !== 0) begin errors++; $display("FAIL wr_no_read: rd mask %0h required 0", rd_mask); end
        checks++;
        if (!addr_ok || other) begin errors++; $display("FAIL wr_addr_hold: addr_ok=%0b other_ack=%0b required 1,0", addr_ok, other); end
        checks++;
        if (mem[11'h003] !== 8'h5A) begin errors++; $display("FAIL wr_sram_data: mem[003]=%h required 5a", mem[11'h003]); end
    endtask

    task automatic test_read_back();
        int ack_step, wr_cnt, wr_step, rd_mask; bit addr_ok, other; logic [DW-1:0] rd;
        drive_single(CLIENT_B, 1'b0, 11'h003, 8'h00, 1'b0, ack_step, wr_cnt, wr_step, rd_mask, addr_ok, rd, other);
        checks++;
        if (ack_step !== 3) begin errors++; $display("FAIL rd_ack_latency: ack at cycle %0d required 3", ack_step); end
        checks++;
        if (rd !== 8'h5A) begin errors++; $display("FAIL rd_data: rdata=%h required 5a", rd); end
        checks++;
        if (rd_mask !== 3) begin errors++; $display("FAIL rd_strobe: rd mask %0h required 3 (SETUP+ACCESS)", rd_mask); end
        checks++;
        if (wr_cnt !== 0 || !addr_ok) begin
            errors++; $display("FAIL rd_pins: wr_cnt=%0d addr_ok=%0b required 0,1", wr_cnt, addr_ok);
        end
    endtask

    task automatic test_mid_change();
        int ack_step, wr_cnt, wr_step, rd_mask; bit addr_ok, other; logic [DW-1:0] rd;
        drive_single(CLIENT_A, 1'b1, 11'h010, 8'hC3, 1'b1, ack_step, wr_cnt, wr_step, rd_mask, addr_ok, rd, other);
        checks++;
        if (mem[11'h010] !== 8'hC3) begin errors++; $display("FAIL mid_change_data: mem[010]=%h required c3", mem[11'h010]); end
        checks++;
        if (!addr_ok || wr_cnt !== 1 || ack_step !== 3) begin
            errors++;
            $display("FAIL mid_change_pins: addr_ok=%0b wr_cnt=%0d ack=%0d required 1,1,3", addr_ok, wr_cnt, ack_step);
        end
    endtask

    task automatic test_contention();
        int      cyc_q[$];
        client_e who_q[$];
        client_e exp;
        bit      both = 1'b0;
        apply_reset();
        set_client(CLIENT_A, 1'b1, 1'b1, 11'h040, 8'h11);
        set_client(CLIENT_B, 1'b1, 1'b1, 11'h041, 8'h22);
        for (int k = 1; k <= 24 && cyc_q.size() < 4; k++) begin
            step();
            if (bus.a_ack && bus.b_ack) both = 1'b1;
            if (bus.a_ack || bus.b_ack) begin
                cyc_q.push_back(k);
                who_q.push_back(bus.a_ack ? CLIENT_A : CLIENT_B);
                if (cyc_q.size() == 4) begin
                    bus.a_req = 1'b0;
                    bus.b_req = 1'b0;
                end
            end
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        step();
        checks++;
        if (cyc_q.size() != 4 || both) begin
            errors++; $display("FAIL cont_count: %0d acks (overlap=%0b) required 4 (0)", cyc_q.size(), both);
        end
        for (int i = 0; i < cyc_q.size(); i++) begin
            exp = mdl_winner(1'b1, 1'b1);
            checks++;
            if (who_q[i] !== exp) begin
                errors++; $display("FAIL cont_order[%0d]: client %s required %s", i, who_q[i].name(), exp.name());
            end
            checks++;
            if (cyc_q[i] !== 3 + 4 * i) begin
                errors++; $display("FAIL cont_timing[%0d]: ack at cycle %0d required %0d", i, cyc_q[i], 3 + 4 * i);
            end
            mdl_last = exp;
        end
        shadow[11'h040] = 8'h11;
        shadow[11'h041] = 8'h22;
        checks++;
        if (mem[11'h040] !== 8'h11 || mem[11'h041] !== 8'h22) begin
            errors++; $display("FAIL cont_data: mem[040]=%h mem[041]=%h required 11 22", mem[11'h040], mem[11'h041]);
        end
    endtask

    task automatic test_random();
        int ack_step, wr_cnt, wr_step, rd_mask; bit addr_ok, other; logic [DW-1:0] rd;
        logic          ra, rb, we_a, we_b, e_we;
        logic [AW-1:0] ad_a, ad_b, e_ad;
        logic [DW-1:0] wd_a, wd_b, e_wd;
        client_e       win;
        for (int a = 0; a < 16; a++) begin
            drive_single(CLIENT_A, 1'b1, AW'(a), DW'($urandom_range(0, 254)), 1'b0,
                         ack_step, wr_cnt, wr_step, rd_mask, addr_ok, rd, other);
            checks++;
            if (ack_step !== 3) begin errors++; $display("FAIL preload[%0d]: ack at cycle %0d required 3", a, ack_step); end
        end
        for (int it = 0; it < 40; it++) begin
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            if (!ra && !rb) ra = 1'b1;
            we_a = 1'($urandom_range(0, 1)); ad_a = AW'($urandom_range(0, 15)); wd_a = DW'($urandom_range(0, 254));
            we_b = 1'($urandom_range(0, 1)); ad_b = AW'($urandom_range(0, 15)); wd_b = DW'($urandom_range(0, 254));
            set_client(CLIENT_A, ra, we_a, ad_a, wd_a);
            set_client(CLIENT_B, rb, we_b, ad_b, wd_b);
            win  = mdl_winner(ra, rb);
            e_we = (win == CLIENT_A) ? we_a : we_b;
            e_ad = (win == CLIENT_A) ? ad_a : ad_b;
            e_wd = (win == CLIENT_A) ? wd_a : wd_b;
            step();
            set_client(CLIENT_A, ra, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom_range(0, 254)));
            set_client(CLIENT_B, rb, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom_range(0, 254)));
            step();
            checks++;
            if ({bus.a_gnt, bus.b_gnt} !== ((win == CLIENT_A) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL rand_gnt[%0d]: a_gnt,b_gnt=%b required winner %s", it, {bus.a_gnt, bus.b_gnt}, win.name());
            end
            step();
            checks++;
            if ({bus.a_ack, bus.b_ack} !== ((win == CLIENT_A) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL rand_ack[%0d]: a_ack,b_ack=%b required winner %s", it, {bus.a_ack, bus.b_ack}, win.name());
            end
            if (e_we) shadow[e_ad] = e_wd;
            else      mdl_rdata = shadow[e_ad];
            checks++;
            if (bus.rdata !== mdl_rdata) begin
                errors++; $display("FAIL rand_rdata[%0d]: rdata=%h required %h (we=%0b addr=%h)", it, bus.rdata, mdl_rdata, e_we, e_ad);
            end
            mdl_last = win;
            bus.a_req = 1'b0;
            bus.b_req = 1'b0;
            step();
        end
        for (int a = 0; a < 16; a++) begin
            checks++;
            if (mem[a] !== shadow[a]) begin
                errors++; $display("FAIL rand_sweep[%0d]: mem=%h required %h", a, mem[a], shadow[a]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int ack_step, wr_cnt, wr_step, rd_mask; bit addr_ok, other; logic [DW-1:0] rd;
        logic [DW-1:0] old;
        old = shadow[11'h005];
        set_client(CLIENT_A, 1'b1, 1'b1, 11'h005, 8'h3C);
        step();
        step();
        checks++;
        if (sram_wr_n !== 1'b0) begin errors++; $display("FAIL abort_setup: wr_n=%b in ACCESS required 0", sram_wr_n); end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (sram_wr_n !== 1'b1 || sram_rd_n !== 1'b1 || sram_data !== {DW{1'b1}}) begin
            errors++; $display("FAIL abort_pins: wr_n=%b rd_n=%b data=%h required 1,1,released", sram_wr_n, sram_rd_n, sram_data);
        end
        checks++;
        if ({bus.busy, bus.a_gnt, bus.a_ack} !== 3'b000) begin
            errors++; $display("FAIL abort_status: busy,gnt,ack=%b required 000", {bus.busy, bus.a_gnt, bus.a_ack});
        end
        step();
        checks++;
        if (mem[11'h005] !== old || bus.a_ack !== 1'b0) begin
            errors++; $display("FAIL abort_no_write: mem[005]=%h ack=%b required %h,0", mem[11'h005], bus.a_ack, old);
        end
        rst = 1'b0;
        mdl_reset();
        drive_single(CLIENT_A, 1'b1, 11'h005, 8'h3C, 1'b0, ack_step, wr_cnt, wr_step, rd_mask, addr_ok, rd, other);
        checks++;
        if (ack_step !== 3 || mem[11'h005] !== 8'h3C) begin
            errors++; $display("FAIL abort_retry: ack at %0d mem[005]=%h required 3,3c", ack_step, mem[11'h005]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_read_back();
        test_mid_change();
        test_contention();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
